// File: rtl/fmap_nibble_stream_reader_if.sv
// Upstream pooling-layer read port plus the downstream pixel stream of the feature-map reader.
// The reader drives through master; the pooling layer and the pixel consumer sit on slave.
interface fmap_nibble_stream_reader_if;
  logic        up_start;
  logic [4:0]  up_image_index;
  logic        up_done;
  logic [31:0] up_read_addr;
  logic [3:0]  up_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [4:0]  out_ch;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic        out_last;

  modport master (
    output up_start, up_image_index, up_read_addr,
    input  up_done, up_read_data,
    output out_valid, out_data, out_ch, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  up_start, up_image_index, up_read_addr,
    output up_done, up_read_data,
    input  out_valid, out_data, out_ch, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/fmap_nibble_stream_reader.sv
// Streams one pooled feature map as nibble beats; READ_LAT+2 cycles per beat with out_ready high.
// out_ready low holds the beat in EMIT with all fields frozen; nothing is buffered.
module fmap_nibble_stream_reader #(
  parameter int CH       = 32,
  parameter int H        = 16,
  parameter int W        = 16,
  parameter int READ_LAT = 2
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               start,
  input  logic [4:0]                         input_image_index,
  input  logic                               order_sel,
  fmap_nibble_stream_reader_if.master        bus,
  output logic                               busy,
  output logic                               done
);

  typedef enum logic [2:0] {IDLE, UP_START, WAIT_UP, ADDR, WAIT_LAT, EMIT, DONE} state_t;

  localparam logic [4:0] CH_MAX  = 5'(CH - 1);
  localparam logic [3:0] H_MAX   = 4'(H - 1);
  localparam logic [3:0] W_MAX   = 4'(W - 1);
  localparam logic [1:0] LAT_MAX = 2'(READ_LAT - 1);

  state_t     state, state_n;
  logic       order_q;
  logic [4:0] ch, ch_n;
  logic [3:0] row, row_n, col, col_n;
  logic [1:0] lat_cnt;
  logic       lat_hit, beat, is_last;

  assign lat_hit = (lat_cnt == LAT_MAX);
  assign beat    = (state == EMIT) && bus.out_ready;
  assign is_last = (ch == CH_MAX) && (row == H_MAX) && (col == W_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = UP_START;
      UP_START: state_n = WAIT_UP;
      WAIT_UP:  if (bus.up_done) state_n = ADDR;
      ADDR:     state_n = WAIT_LAT;
      WAIT_LAT: if (lat_hit) state_n = EMIT;
      EMIT:     if (bus.out_ready) state_n = bus.out_last ? DONE : ADDR;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.up_start  = (state == UP_START);
    bus.out_valid = (state == EMIT);
    busy          = (state != IDLE);
    done          = (state == DONE);
  end

  // order_q=0: col, row, ch from fastest to slowest; order_q=1: ch, col, row.
  always_comb begin
    ch_n  = ch;
    row_n = row;
    col_n = col;
    if (!order_q) begin
      col_n = (col == W_MAX) ? 4'd0 : col + 4'd1;
      if (col == W_MAX) begin
        row_n = (row == H_MAX) ? 4'd0 : row + 4'd1;
        if (row == H_MAX) ch_n = (ch == CH_MAX) ? 5'd0 : ch + 5'd1;
      end
    end else begin
      ch_n = (ch == CH_MAX) ? 5'd0 : ch + 5'd1;
      if (ch == CH_MAX) begin
        col_n = (col == W_MAX) ? 4'd0 : col + 4'd1;
        if (col == W_MAX) row_n = (row == H_MAX) ? 4'd0 : row + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      order_q            <= 1'b0;
      bus.up_image_index <= '0;
      bus.up_read_addr   <= '0;
      bus.out_data       <= '0;
      bus.out_ch         <= '0;
      bus.out_row        <= '0;
      bus.out_col        <= '0;
      bus.out_last       <= 1'b0;
      ch                 <= '0;
      row                <= '0;
      col                <= '0;
      lat_cnt            <= '0;
    end else begin
      if (state == IDLE && start) begin
        bus.up_image_index <= input_image_index;
        order_q            <= order_sel;
      end
      if (state == WAIT_UP && bus.up_done) begin
        ch  <= '0;
        row <= '0;
        col <= '0;
      end
      if (state == ADDR) begin
        bus.up_read_addr <= 32'(ch) * 32'(H * W) + 32'(row) * 32'(W) + 32'(col);
        lat_cnt          <= '0;
      end
      // The address stays put through WAIT_LAT and EMIT, so the capture sees a settled read.
      if (state == WAIT_LAT) begin
        lat_cnt <= lat_cnt + 2'd1;
        if (lat_hit) begin
          bus.out_data <= bus.up_read_data;
          bus.out_ch   <= ch;
          bus.out_row  <= row;
          bus.out_col  <= col;
          bus.out_last <= is_last;
        end
      end
      if (beat) begin
        ch           <= ch_n;
        row          <= row_n;
        col          <= col_n;
        bus.out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fmap_nibble_stream_reader.sv
// Directed bench: READ_LAT=2 reader under full checks, READ_LAT=1 and 4 readers on the same stimulus.
module tb_fmap_nibble_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, start, order_sel, up_done, rdy, rand_rdy;
  logic [4:0] img;
  logic       busy_m, done_m, busy_1, done_1, busy_4, done_4;

  fmap_nibble_stream_reader_if m_if ();
  fmap_nibble_stream_reader_if a1_if ();
  fmap_nibble_stream_reader_if a4_if ();

  fmap_nibble_stream_reader #(.READ_LAT(2)) u_main (
    .clk(clk), .resetn(resetn), .start(start), .input_image_index(img),
    .order_sel(order_sel), .bus(m_if), .busy(busy_m), .done(done_m));
  fmap_nibble_stream_reader #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .resetn(resetn), .start(start), .input_image_index(img),
    .order_sel(order_sel), .bus(a1_if), .busy(busy_1), .done(done_1));
  fmap_nibble_stream_reader #(.READ_LAT(4)) u_lat4 (
    .clk(clk), .resetn(resetn), .start(start), .input_image_index(img),
    .order_sel(order_sel), .bus(a4_if), .busy(busy_4), .done(done_4));

  function automatic logic [3:0] nib(input logic [31:0] a);
    return a[3:0] ^ a[11:8];
  endfunction

  // Address of beat k for a 32x16x16 map in either scan order.
  function automatic logic [31:0] exp_addr(input int k, input logic ord);
    int c, r, w;
    if (!ord) return 32'(k);
    c = k % 32;
    w = (k / 32) % 16;
    r = k / 512;
    return 32'(c * 256 + r * 16 + w);
  endfunction

  // Memory models: READ_LAT-1 register stages in front of the nibble lookup.
  logic [3:0] m_pipe;
  logic [3:0] a4_pipe [3];
  assign a1_if.up_read_data = nib(a1_if.up_read_addr);
  assign m_if.up_read_data  = m_pipe;
  assign a4_if.up_read_data = a4_pipe[2];
  always @(posedge clk) begin
    m_pipe     <= nib(m_if.up_read_addr);
    a4_pipe[0] <= nib(a4_if.up_read_addr);
    a4_pipe[1] <= a4_pipe[0];
    a4_pipe[2] <= a4_pipe[1];
  end

  assign m_if.up_done   = up_done;
  assign a1_if.up_done  = up_done;
  assign a4_if.up_done  = up_done;
  assign m_if.out_ready = rdy;
  assign a1_if.out_ready = 1'b1;
  assign a4_if.out_ready = 1'b1;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  int          mk = 0, m_ups = 0, m_dones = 0, n_stall = 0, last_k = -1, k1 = 0, k4 = 0;
  logic        m_prev_acc = 1'b0, m_prev_stall = 1'b0;
  logic [17:0] cur, snap;
  logic [31:0] ea, ea1, ea4;
  logic [31:0] cap_addr [64];
  logic [12:0] cap_crd [64];
  logic [12:0] last_crd;

  always @(negedge clk) begin
    if (!resetn) begin
      m_prev_acc   = 1'b0;
      m_prev_stall = 1'b0;
      rdy          = 1'b1;
    end else begin
      cur = {m_if.out_data, m_if.out_ch, m_if.out_row, m_if.out_col, m_if.out_last};
      if (m_if.up_start) begin
        m_ups++;
        mk = 0;
      end
      if (done_m) m_dones++;
      if (m_prev_acc) chk("valid_drop", 32'(m_if.out_valid), 32'd0);
      if (m_prev_stall) chk("stall_hold", 32'({m_if.out_valid, cur}), 32'({1'b1, snap}));
      rdy = rand_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
      m_prev_acc   = m_if.out_valid && rdy;
      m_prev_stall = m_if.out_valid && !rdy;
      if (m_prev_stall) n_stall++;
      if (m_prev_acc) begin
        ea = exp_addr(mk, order_sel);
        chk("addr", m_if.up_read_addr, ea);
        chk("data", 32'(m_if.out_data), 32'(nib(ea)));
        chk("coord", 32'({m_if.out_ch, m_if.out_row, m_if.out_col}), 32'({ea[12:8], ea[7:4], ea[3:0]}));
        chk("last", 32'(m_if.out_last), 32'(mk == 8191));
        if (mk < 64) begin
          cap_addr[mk] = m_if.up_read_addr;
          cap_crd[mk]  = {m_if.out_ch, m_if.out_row, m_if.out_col};
        end
        if (m_if.out_last) begin
          last_k   = mk;
          last_crd = {m_if.out_ch, m_if.out_row, m_if.out_col};
        end
        mk++;
      end
      snap = cur;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (a1_if.up_start) k1 = 0;
      if (a4_if.up_start) k4 = 0;
      if (a1_if.out_valid) begin
        ea1 = exp_addr(k1, order_sel);
        chk("l1_addr", a1_if.up_read_addr, ea1);
        chk("l1_data", 32'(a1_if.out_data), 32'(nib(ea1)));
        k1++;
      end
      if (a4_if.out_valid) begin
        ea4 = exp_addr(k4, order_sel);
        chk("l4_addr", a4_if.up_read_addr, ea4);
        chk("l4_data", 32'(a4_if.out_data), 32'(nib(ea4)));
        k4++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_up_done();
    up_done = 1'b1;
    @(negedge clk);
    up_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({busy_m, done_m, m_if.up_start, m_if.out_valid, m_if.out_last}), 32'd0);
    chk({tag, "_addr"}, m_if.up_read_addr, 32'd0);
    chk({tag, "_dat"}, 32'({m_if.out_data, m_if.out_ch, m_if.out_row, m_if.out_col, m_if.up_image_index}), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   t, kr;
    logic seen;
    resetn = 1'b0; start = 1'b0; order_sel = 1'b0; img = 5'd9; up_done = 1'b0; rand_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy_m), 32'd0);

    // Channel-major full map, ready held high, extra starts in WAIT_UP and EMIT.
    pulse_start();
    chk("up_start_hi", 32'(m_if.up_start), 32'd1);
    chk("img_latch", 32'(m_if.up_image_index), 32'd9);
    chk("busy_hi", 32'(busy_m), 32'd1);
    @(negedge clk);
    chk("up_start_lo", 32'(m_if.up_start), 32'd0);
    img = 5'd3;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("no_restart", 32'(m_ups), 32'd1);
    chk("img_kept", 32'(m_if.up_image_index), 32'd9);
    pulse_up_done();
    t = 0;
    while (!m_if.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("first_valid", 32'(m_if.out_valid), 32'd1);
    pulse_start();
    t = 0; seen = 1'b0;
    while (!seen && t < 40000) begin
      @(negedge clk);
      if (done_m) seen = 1'b1;
      t++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("beats", 32'(mk), 32'd8192);
    chk("done_once", 32'(m_dones), 32'd1);
    chk("up_start_once", 32'(m_ups), 32'd1);
    chk("idle_after", 32'(busy_m), 32'd0);
    chk("beat0_addr", cap_addr[0], 32'd0);
    chk("beat0_crd", 32'(cap_crd[0]), 32'd0);
    chk("last_k", 32'(last_k), 32'd8191);
    chk("last_crd", 32'(last_crd), 32'({5'd31, 4'd15, 4'd15}));

    // Random ready at 30 percent, reset dropped at beat 500.
    img = 5'd21;
    rand_rdy = 1'b1;
    pulse_start();
    chk("img2_latch", 32'(m_if.up_image_index), 32'd21);
    @(negedge clk);
    pulse_up_done();
    t = 0;
    while (mk < 500 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_500", 32'(mk >= 500), 32'd1);
    chk("stalls_seen", 32'(n_stall > 100), 32'd1);
    #2 resetn = 1'b0;
    #1 check_all_zero("async_rst");
    kr = mk;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    rand_rdy = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_beats_after_rst", 32'(mk), 32'(kr));
    chk("idle_after_rst", 32'(busy_m), 32'd0);

    // Pixel-major restart after the abandoned map.
    order_sel = 1'b1;
    pulse_start();
    @(negedge clk);
    pulse_up_done();
    t = 0;
    while ((mk < 40 || k4 < 40) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("restart_addr0", cap_addr[0], 32'd0);
    chk("pm_beat1_addr", cap_addr[1], 32'd256);
    chk("pm_beat1_crd", 32'(cap_crd[1]), 32'({5'd1, 4'd0, 4'd0}));
    chk("pm_beat32_addr", cap_addr[32], 32'd1);
    chk("pm_beat32_crd", 32'(cap_crd[32]), 32'({5'd0, 4'd0, 4'd1}));
    chk("l1_progress", 32'(k1 >= 40), 32'd1);
    chk("l4_progress", 32'(k4 >= 40), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fmap_nibble_stream_reader.md
FMAP_NIBBLE_STREAM_READER -- requirements
Module: fmap_nibble_stream_reader

Interface
REQ-001 The block SHALL have parameter CH, default 32: channel count of the pooled feature map.
REQ-002 The block SHALL have parameter H, default 16: rows per channel.
REQ-003 The block SHALL have parameter W, default 16: columns per channel.
REQ-004 The block SHALL have parameter READ_LAT, default 2: cycles from up_read_addr stable to up_read_data valid; legal range 1..4.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle request to stream one full feature map.
REQ-008 The block SHALL have port input_image_index, input, 5 bits: image selector, sampled at accepted start.
REQ-009 The block SHALL have port order_sel, input, 1 bit, sampled at accepted start: 0 = channel-major order, 1 = pixel-major order (channel innermost).
REQ-010 The block SHALL have port up_start, output, 1 bit: one-cycle start pulse to the upstream pooling layer.
REQ-011 The block SHALL have port up_image_index, output, 5 bits: the latched image index.
REQ-012 The block SHALL have port up_done, input, 1 bit: upstream completion pulse.
REQ-013 The block SHALL have port up_read_addr, output, 32 bits: nibble address into upstream storage.
REQ-014 The block SHALL have port up_read_data, input, 4 bits: nibble at up_read_addr.
REQ-015 The block SHALL have port out_valid, output, 1 bit; out_ready, input, 1 bit: output handshake.
REQ-016 The block SHALL have port out_data, output, 4 bits; out_ch, output, 5 bits; out_row, output, 4 bits; out_col, output, 4 bits: pixel value and its coordinates.
REQ-017 The block SHALL have port out_last, output, 1 bit: marks the final pixel of the map.
REQ-018 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-019 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final beat is accepted.

Function
REQ-020 The states SHALL be IDLE, UP_START, WAIT_UP, ADDR, WAIT_LAT, EMIT, DONE.
REQ-021 In IDLE, start SHALL latch input_image_index and order_sel, assert up_start for exactly one cycle, and move to UP_START then WAIT_UP; start SHALL be ignored in every other state.
REQ-022 In WAIT_UP, up_done SHALL clear the ch/row/col counters to 0 and move to ADDR; the block SHALL wait indefinitely otherwise.
REQ-023 In ADDR, up_read_addr SHALL be driven to ch*H*W + row*W + col, zero-extended to 32 bits, and held unchanged until EMIT completes.
REQ-024 WAIT_LAT SHALL last exactly READ_LAT cycles, after which up_read_data is captured into out_data and the state moves to EMIT with out_valid=1.
REQ-025 In EMIT, out_data, out_ch, out_row, out_col and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 A beat SHALL transfer on a cycle where out_valid=1 and out_ready=1; out_valid SHALL drop the next cycle, with counters advanced and the state moving to ADDR, or to DONE if out_last was set.
REQ-027 With order_sel=0, col SHALL advance fastest, then row, then ch.
REQ-028 With order_sel=1, ch SHALL advance fastest, then col, then row.
REQ-029 Each counter SHALL wrap to 0 at its limit (CH-1, H-1, W-1), carrying into the next counter.
REQ-030 out_last SHALL be 1 only on the beat at ch=CH-1, row=H-1, col=W-1.
REQ-031 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-032 The block SHALL emit exactly CH*H*W beats per start, with no duplicates or gaps.

Reset
REQ-033 While resetn=0, the block SHALL force state IDLE.
REQ-034 While resetn=0, up_start, out_valid, out_last, busy and done SHALL be 0.
REQ-035 While resetn=0, up_read_addr, out_data, out_ch, out_row, out_col, up_image_index and all counters SHALL be 0.
REQ-036 Reset asserted mid-stream SHALL abandon the map with no further beats; the next start SHALL begin a fresh map from (0,0,0).

Verification
REQ-037 Channel-major order, out_ready held at 1, memory model nibble = addr[3:0] ^ addr[11:8]: the bench SHALL see 8192 beats; beat k has up_read_addr=k; beat 0 has ch=0,row=0,col=0; beat 8191 has ch=31,row=15,col=15 with out_last=1; done pulses exactly once.
REQ-038 Pixel-major order: beat 1 SHALL have ch=1,row=0,col=0 at address 256, and beat 32 SHALL have ch=0,row=0,col=1 at address 1.
REQ-039 Random out_ready with 30% duty: the bench SHALL see no data or coordinate change while stalled, and an identical beat sequence to REQ-037.
REQ-040 Start asserted during WAIT_UP and during EMIT SHALL be ignored: no second up_start, beat count still 8192.
REQ-041 resetn pulsed low at beat 500: all outputs SHALL read 0 asynchronously; a new start SHALL restart from address 0.
REQ-042 READ_LAT=1 and READ_LAT=4 builds SHALL capture the correct nibble under a model with the matching latency.
